mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates a single-ported memory between a CPU and a debug/loader port.
// Every access takes one grant cycle. The CPU is stalled while it requests and
// is not granted. The debug port may hold the bus for a locked burst, but only
// for BURST_MAX consecutive grants while the CPU is waiting.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   cpu_req/we/adr/wdata  : CPU request side
//   cpu_stall, cpu_rdata  : CPU response (both combinational)
//   dbg_req/we/lock/adr/wdata : debug request side (lock asks to keep a burst)
//   dbg_gnt               : debug access happens this cycle
//   dbg_done              : one-cycle pulse after each debug grant cycle
//   dbg_rdata             : debug read data, registered at the end of a read
//   mem_adr/wdata/we      : memory request, muxed from the current owner
//   mem_rdata             : memory read data, combinational from mem_adr
//   status                : {state, last_owner, burst_cnt, cpu_stall, dbg_gnt}
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_adr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic        dbg_lock,
    input  logic [15:0] dbg_adr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_done,
    output logic [15:0] dbg_rdata,
    output logic [15:0] mem_adr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  status
);

    localparam logic [1:0]  ST_IDLE   = 2'b00;
    localparam logic [1:0]  ST_CPU    = 2'b01;
    localparam logic [1:0]  ST_DBG    = 2'b10;
    localparam logic [2:0]  BURST_SAT = 3'd7;
    localparam logic [31:0] BURST_LIM = BURST_MAX - 32'd1;

    logic [1:0]  state_q,      state_d;
    logic        last_owner_q, last_owner_d;   // 0 = CPU, 1 = debug
    logic [2:0]  burst_cnt_q,  burst_cnt_d;
    logic        dbg_done_q,   dbg_done_d;
    logic [15:0] dbg_rdata_q,  dbg_rdata_d;

    logic        in_cpu_s;
    logic        in_dbg_s;
    logic        burst_ok_s;

    assign in_cpu_s = (state_q == ST_CPU);
    assign in_dbg_s = (state_q == ST_DBG);

    // A locked burst may continue freely while the CPU is quiet; once the CPU
    // waits, the burst may run only until BURST_MAX grants have been given.
    assign burst_ok_s = (~cpu_req) | ({29'd0, burst_cnt_q} < BURST_LIM);

    // Next-state selection for the grant FSM.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && dbg_req) begin
                    // Both waiting: give the bus to whoever did not have it last.
                    state_d = last_owner_q ? ST_CPU : ST_DBG;
                end else if (cpu_req) begin
                    state_d = ST_CPU;
                end else if (dbg_req) begin
                    state_d = ST_DBG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (dbg_req) begin
                    state_d = ST_DBG;
                end else if (cpu_req) begin
                    state_d = ST_CPU;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DBG: begin
                if (dbg_req && dbg_lock && burst_ok_s) begin
                    state_d = ST_DBG;
                end else if (cpu_req) begin
                    state_d = ST_CPU;
                end else if (dbg_req) begin
                    state_d = ST_DBG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bookkeeping that follows the grant decision: burst length, owner, debug
    // completion pulse and captured debug read data.
    always_comb begin
        burst_cnt_d  = 3'd0;
        last_owner_d = last_owner_q;
        dbg_done_d   = in_dbg_s;
        dbg_rdata_d  = dbg_rdata_q;

        // Only debug-to-debug transitions extend a burst; any other move
        // (into CPU, IDLE, or a fresh debug grant) starts from zero.
        if (in_dbg_s && (state_d == ST_DBG)) begin
            if (burst_cnt_q == BURST_SAT) begin
                burst_cnt_d = BURST_SAT;
            end else begin
                burst_cnt_d = burst_cnt_q + 3'd1;
            end
        end else begin
            burst_cnt_d = 3'd0;
        end

        // The owner is loaded as its grant begins. An access always finishes
        // within its single grant cycle, so during and after that cycle this
        // names the owner of the most recent access.
        case (state_d)
            ST_CPU:  last_owner_d = 1'b0;
            ST_DBG:  last_owner_d = 1'b1;
            default: last_owner_d = last_owner_q;
        endcase

        if (in_dbg_s && !dbg_we) begin
            dbg_rdata_d = mem_rdata;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    // State registers with synchronous reset; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= 3'd0;
            dbg_done_q   <= 1'b0;
            dbg_rdata_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            dbg_done_q   <= dbg_done_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Memory request mux: driven by the current owner, quiet when idle.
    always_comb begin
        mem_adr   = 16'h0000;
        mem_wdata = 16'h0000;
        mem_we    = 1'b0;
        case (state_q)
            ST_CPU: begin
                mem_adr   = cpu_adr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            ST_DBG: begin
                mem_adr   = dbg_adr;
                mem_wdata = dbg_wdata;
                mem_we    = dbg_we;
            end
            default: begin
                mem_adr   = 16'h0000;
                mem_wdata = 16'h0000;
                mem_we    = 1'b0;
            end
        endcase
    end

    // Requester-facing responses.
    always_comb begin
        cpu_stall = cpu_req & ~in_cpu_s;
        if (in_cpu_s) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = 16'h0000;
        end
        dbg_gnt = in_dbg_s;
    end

    assign dbg_done  = dbg_done_q;
    assign dbg_rdata = dbg_rdata_q;
    assign status    = {state_q, last_owner_q, burst_cnt_q, cpu_stall, dbg_gnt};

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural model of the
// arbitration rules predicts every output for each cycle; the prediction is
// queued when the cycle's inputs are driven, and a separate monitor pops and
// compares it against the design mid-cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int G_IDLE = 0;
    localparam int G_CPU  = 1;
    localparam int G_DBG  = 2;
    localparam int BMAX   = 8;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_adr, cpu_wdata;
    logic        cpu_stall;
    logic [15:0] cpu_rdata;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [15:0] dbg_adr, dbg_wdata;
    logic        dbg_gnt, dbg_done;
    logic [15:0] dbg_rdata;
    logic [15:0] mem_adr, mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [7:0]  status;

    mem_arbiter #(.BURST_MAX(BMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_lock  (dbg_lock),
        .dbg_adr   (dbg_adr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_done  (dbg_done),
        .dbg_rdata (dbg_rdata),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .status    (status)
    );

    // Read-only memory contents: a fixed function of the address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0010) begin
            return 16'hBEEF;
        end
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign mem_rdata = mem_fn(mem_adr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          check;
        logic [15:0] mem_adr;
        logic [15:0] mem_wdata;
        logic        mem_we;
        logic        cpu_stall;
        logic [15:0] cpu_rdata;
        logic        dbg_gnt;
        logic        dbg_done;
        logic [15:0] dbg_rdata;
        logic [7:0]  status;
        bit          has_run;
        int          stall_run;
        int          gnt_run;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, who owned it last, how long the
    // current debug run is, and what the debug side last saw.
    int          m_g     = G_IDLE;
    bit          m_last  = 1'b1;
    int          m_burst = 0;
    logic [15:0] m_rd    = 16'h0000;
    bit          m_done  = 1'b0;
    bit          m_known = 1'b0;

    function automatic logic [1:0] st_bits(input int g);
        if (g == G_CPU) return 2'b01;
        if (g == G_DBG) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_advance();
        int nxt;
        if (reset) begin
            m_g = G_IDLE; m_last = 1'b1; m_burst = 0;
            m_rd = 16'h0000; m_done = 1'b0; m_known = 1'b1;
        end else begin
            nxt = G_IDLE;
            if (m_g == G_IDLE) begin
                if (cpu_req && dbg_req) nxt = m_last ? G_CPU : G_DBG;
                else if (cpu_req)       nxt = G_CPU;
                else if (dbg_req)       nxt = G_DBG;
            end else if (m_g == G_CPU) begin
                if (dbg_req)      nxt = G_DBG;
                else if (cpu_req) nxt = G_CPU;
            end else begin
                if (dbg_req && dbg_lock && (!cpu_req || m_burst < BMAX - 1)) nxt = G_DBG;
                else if (cpu_req) nxt = G_CPU;
                else if (dbg_req) nxt = G_DBG;
            end
            m_done = (m_g == G_DBG);
            if (m_g == G_DBG && !dbg_we) m_rd = mem_fn(dbg_adr);
            if (nxt == G_CPU) m_last = 1'b0;
            if (nxt == G_DBG) m_last = 1'b1;
            if (m_g == G_DBG && nxt == G_DBG) m_burst = (m_burst >= 7) ? 7 : m_burst + 1;
            else m_burst = 0;
            m_g = nxt;
        end
    endtask

    // Predict this cycle's outputs from the current inputs, queue them, then
    // let the clock edge happen and move the model along.
    task automatic tick(input bit has_run, input int exp_sr, input int exp_gr);
        exp_t e;
        e.check     = m_known;
        e.mem_adr   = 16'h0000;
        e.mem_wdata = 16'h0000;
        e.mem_we    = 1'b0;
        if (m_g == G_CPU) begin
            e.mem_adr = cpu_adr; e.mem_wdata = cpu_wdata; e.mem_we = cpu_we;
        end else if (m_g == G_DBG) begin
            e.mem_adr = dbg_adr; e.mem_wdata = dbg_wdata; e.mem_we = dbg_we;
        end
        e.cpu_stall = cpu_req && (m_g != G_CPU);
        e.cpu_rdata = (m_g == G_CPU) ? mem_fn(cpu_adr) : 16'h0000;
        e.dbg_gnt   = (m_g == G_DBG);
        e.dbg_done  = m_done;
        e.dbg_rdata = m_rd;
        e.status    = {st_bits(m_g), m_last, 3'(m_burst), e.cpu_stall, e.dbg_gnt};
        e.has_run   = has_run;
        e.stall_run = exp_sr;
        e.gnt_run   = exp_gr;
        sb_q.push_back(e);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks run lengths of stall and debug grant, and checks each
    // cycle against the queued prediction.
    int cur_stall = 0, last_stall = 0, cur_gnt = 0, last_gnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_stall === 1'b1) cur_stall++;
            else begin
                if (cur_stall > 0) last_stall = cur_stall;
                cur_stall = 0;
            end
            if (dbg_gnt === 1'b1) cur_gnt++;
            else begin
                if (cur_gnt > 0) last_gnt = cur_gnt;
                cur_gnt = 0;
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.check) begin
                    chk("mem_adr",   32'(mem_adr),   32'(e.mem_adr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(e.mem_wdata));
                    chk("mem_we",    32'(mem_we),    32'(e.mem_we));
                    chk("cpu_stall", 32'(cpu_stall), 32'(e.cpu_stall));
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(e.cpu_rdata));
                    chk("dbg_gnt",   32'(dbg_gnt),   32'(e.dbg_gnt));
                    chk("dbg_done",  32'(dbg_done),  32'(e.dbg_done));
                    chk("dbg_rdata", 32'(dbg_rdata), 32'(e.dbg_rdata));
                    chk("status",    32'(status),    32'(e.status));
                end
                if (e.has_run) begin
                    chk("stall_run", 32'(last_stall), 32'(e.stall_run));
                    chk("gnt_run",   32'(last_gnt),   32'(e.gnt_run));
                end
            end
        end
    end

    task automatic quiet();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 16'h0000; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
        dbg_adr = 16'h0000; dbg_wdata = 16'h0000;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        @(posedge clk);
        #1;
        tick(1'b0, 0, 0);                 // model state unknown: not checked
        tick(1'b0, 0, 0);                 // reset state checked here
        reset = 1'b0;

        // CPU read of 0x0010 from idle, then a second access, then release.
        cpu_req = 1'b1; cpu_adr = 16'h0010;
        tick(1'b0, 0, 0);                 // IDLE, stalled
        tick(1'b0, 0, 0);                 // CPU, rdata BEEF, status 0x40
        cpu_req = 1'b0;
        tick(1'b0, 0, 0);                 // CPU, last access

        // Debug write from idle.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 16'h0020; dbg_wdata = 16'h1234;
        tick(1'b0, 0, 0);                 // IDLE
        dbg_req = 1'b0;
        tick(1'b0, 0, 0);                 // DBG write cycle
        quiet();
        tick(1'b0, 0, 0);                 // done pulse, rdata unchanged

        // Both requesting continuously from reset: alternating grants.
        reset = 1'b1;
        tick(1'b0, 0, 0);
        reset = 1'b0;
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_adr = 16'h0100; dbg_adr = 16'h0200;
        for (int i = 0; i < 7; i++) tick(1'b0, 0, 0);
        quiet();
        tick(1'b0, 0, 0);                 // final CPU grant, then IDLE, last=CPU

        // Locked debug burst against a waiting CPU: 8 debug grants, 9 stalls.
        cpu_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b0;
        cpu_adr = 16'h0300;
        tick(1'b0, 0, 0);                 // IDLE, goes to DBG
        for (int i = 0; i < BMAX; i++) begin
            dbg_adr = 16'(16'h0400 + i);
            tick(1'b0, 0, 0);
        end
        quiet();
        tick(1'b1, BMAX + 1, BMAX);       // CPU finally granted

        // Reset in the middle of a debug read.
        dbg_req = 1'b1; dbg_adr = 16'h0033;
        tick(1'b0, 0, 0);                 // IDLE
        tick(1'b0, 0, 0);                 // DBG read, stays
        reset = 1'b1; dbg_adr = 16'h0044;
        tick(1'b0, 0, 0);                 // DBG read aborted by reset
        reset = 1'b0; quiet();
        tick(1'b0, 0, 0);                 // IDLE, no done, rdata cleared

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            cpu_req   = ($urandom_range(0, 99) < 60);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_adr   = 16'($urandom_range(0, 255));
            cpu_wdata = 16'($urandom);
            dbg_req   = ($urandom_range(0, 99) < 55);
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_lock  = ($urandom_range(0, 99) < 70);
            dbg_adr   = 16'($urandom_range(0, 255));
            dbg_wdata = 16'($urandom);
            tick(1'b0, 0, 0);
        end

        reset = 1'b0; quiet();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
